mcu_control_unit: RTL and testbench

//   Fetch/decode/execute sequencer for the 8-bit MCU. It is the initiator on the ALU

---
 rtl/mcu_pkg.sv | 34 +++
 rtl/mcu_if.sv | 16 +
 rtl/mcu_decoder.sv | 29 ++
 rtl/mcu_control_unit.sv | 121 ++++++++++++
 tb/tb_mcu_control_unit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/mcu_pkg.sv
// Shared definitions for the 8-bit MCU control unit: widths, opcodes,
// FSM state encoding and the decoded-instruction bundle.
package mcu_pkg;

  localparam int PC_W    = 8;
  localparam int INSTR_W = 12;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDA  = 4'h1;
  localparam logic [3:0] OP_LDB  = 4'h2;
  localparam logic [3:0] OP_ALU  = 4'h3;
  localparam logic [3:0] OP_JMP  = 4'h4;
  localparam logic [3:0] OP_JZ   = 4'h5;
  localparam logic [3:0] OP_OUT  = 4'h6;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_HALT   = 3'd4;

  typedef struct packed {
    logic is_alu;
    logic is_ld_a;
    logic is_ld_b;
    logic is_jmp;
    logic is_jz;
    logic is_out;
    logic is_halt;
    logic illegal;
  } dec_t;

endpackage

// File: rtl/mcu_if.sv
// ALU operation interface: the control unit (master) drives operands, mode
// and enable; the ALU (slave) returns a combinational result and flags.
interface mcu_if;
  logic [7:0] Operand1;
  logic [7:0] Operand2;
  logic [3:0] Mode;
  logic       E;
  logic [7:0] Out;
  logic [3:0] CFlags;
  logic       Flags;

  modport master (output Operand1, Operand2, Mode, E,
                  input  Out, CFlags, Flags);
  modport slave  (input  Operand1, Operand2, Mode, E,
                  output Out, CFlags, Flags);
endinterface

// File: rtl/mcu_decoder.sv
// Combinational opcode decoder: IR -> one-hot-ish instruction class flags.
// Opcodes 7..E are undefined; they act as NOP and raise 'illegal'.
module mcu_decoder
  import mcu_pkg::*;
(
  input  logic [INSTR_W-1:0] ir_i,
  output dec_t               dec_o
);

  logic [3:0] opcode;
  assign opcode = ir_i[INSTR_W-1 -: 4];

  // Classify the opcode field
  always_comb begin
    dec_o = '0;
    unique case (opcode)
      OP_NOP:  ;
      OP_LDA:  dec_o.is_ld_a = 1'b1;
      OP_LDB:  dec_o.is_ld_b = 1'b1;
      OP_ALU:  dec_o.is_alu  = 1'b1;
      OP_JMP:  dec_o.is_jmp  = 1'b1;
      OP_JZ:   dec_o.is_jz   = 1'b1;
      OP_OUT:  dec_o.is_out  = 1'b1;
      OP_HALT: dec_o.is_halt = 1'b1;
      default: dec_o.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mcu_control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit MCU. Each instruction takes
// FETCH (address out), DECODE (IMEM data into IR), EXEC (act, advance PC).
// Optional feature: MCU_SINGLE_STEP_EN adds a Step input that gates FETCH.
module mcu_control_unit
  import mcu_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               Start,
`ifdef MCU_SINGLE_STEP_EN
  input  logic               Step,
`endif
  output logic [PC_W-1:0]    PcAddr,
  input  logic [INSTR_W-1:0] Instr,
  mcu_if.master              alu,
  output logic [7:0]         DataOut,
  output logic               OutValid,
  output logic [4:0]         FlagReg,
  output logic               Halted,
  output logic               IllegalOp
);

  logic [2:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q;
  logic [7:0]         acc_q, dr_q, dout_q;
  logic [3:0]         mode_q;
  logic [4:0]         flag_q;
  logic               ovld_q, ill_q;
  logic               step_ok;
  logic               in_exec;
  logic [7:0]         imm;
  dec_t               dec;

  mcu_decoder u_dec (
    .ir_i  (ir_q),
    .dec_o (dec)
  );

`ifdef MCU_SINGLE_STEP_EN
  assign step_ok = Step;
`else
  assign step_ok = 1'b1;
`endif

  assign imm     = ir_q[7:0];
  assign in_exec = (state_q == ST_EXEC);

  // Sequencer next state; Start only matters in IDLE, HALT is a sink
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (Start) state_d = ST_FETCH;
      ST_FETCH:  if (step_ok) state_d = ST_DECODE;
      ST_DECODE: state_d = ST_EXEC;
      ST_EXEC:   state_d = dec.is_halt ? ST_HALT : ST_FETCH;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next PC: jumps load imm, everything else increments (wraps 255 -> 0)
  always_comb begin
    pc_d = pc_q + 1'b1;
    if (dec.is_jmp || (dec.is_jz && (acc_q == 8'd0))) pc_d = imm;
  end

  // FSM, PC and IR registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_DECODE) ir_q <= Instr;
      if (in_exec)              pc_q <= pc_d;
    end
  end

  // Datapath registers written at the end of EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      dr_q   <= '0;
      mode_q <= '0;
      flag_q <= '0;
      dout_q <= '0;
      ovld_q <= 1'b0;
      ill_q  <= 1'b0;
    end else begin
      ovld_q <= 1'b0;
      if (in_exec) begin
        if (dec.is_ld_a) acc_q <= imm;
        if (dec.is_ld_b) dr_q  <= imm;
        if (dec.is_alu) begin
          acc_q  <= alu.Out;
          flag_q <= {alu.Flags, alu.CFlags};
          mode_q <= ir_q[3:0];
        end
        if (dec.is_out) begin
          dout_q <= acc_q;
          ovld_q <= 1'b1;
        end
        if (dec.illegal) ill_q <= 1'b1;
      end
    end
  end

  assign PcAddr       = pc_q;
  assign alu.Operand1 = acc_q;
  assign alu.Operand2 = dr_q;
  assign alu.E        = in_exec && dec.is_alu;
  assign alu.Mode     = alu.E ? ir_q[3:0] : mode_q;
  assign DataOut      = dout_q;
  assign OutValid     = ovld_q;
  assign FlagReg      = flag_q;
  assign Halted       = (state_q == ST_HALT);
  assign IllegalOp    = ill_q;

endmodule

// File: tb/tb_mcu_control_unit.sv
// Directed bench for mcu_control_unit with a 1-cycle IMEM model and an ALU
// stub (Mode 0 add, Mode 1 sub, CFlags[0] = carry/borrow, Flags = Out==0).
module tb_mcu_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        Start = 1'b0;
`ifdef MCU_SINGLE_STEP_EN
  logic        Step = 1'b1;
`endif
  logic [7:0]  PcAddr;
  logic [11:0] Instr = '0;
  logic [7:0]  DataOut;
  logic        OutValid;
  logic [4:0]  FlagReg;
  logic        Halted;
  logic        IllegalOp;

  logic [11:0] imem [256];
  int n_chk = 0;
  int n_err = 0;

  mcu_if alu_if ();

  mcu_control_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .Start     (Start),
`ifdef MCU_SINGLE_STEP_EN
    .Step      (Step),
`endif
    .PcAddr    (PcAddr),
    .Instr     (Instr),
    .alu       (alu_if),
    .DataOut   (DataOut),
    .OutValid  (OutValid),
    .FlagReg   (FlagReg),
    .Halted    (Halted),
    .IllegalOp (IllegalOp)
  );

  always #5 clk = ~clk;

  always @(posedge clk) Instr <= imem[PcAddr];

  logic [8:0] alu_sum;
  always_comb begin
    alu_sum = '0;
    if (alu_if.Mode == 4'd1) alu_sum = {1'b0, alu_if.Operand1} - {1'b0, alu_if.Operand2};
    else                     alu_sum = {1'b0, alu_if.Operand1} + {1'b0, alu_if.Operand2};
    alu_if.Out    = alu_sum[7:0];
    alu_if.CFlags = {3'b000, alu_sum[8]};
    alu_if.Flags  = (alu_sum[7:0] == 8'd0);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    Start = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 12'h000;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Leaves the bench at the falling edge right after the edge that took Start
  task automatic start_prog();
    Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    int e_cnt, v_cnt;
    logic [7:0] v_data;

    // Reset state
    do_reset();
    check("rst_pc",   PcAddr, 8'h00);
    check("rst_dout", DataOut, 8'h00);
    check("rst_ovld", OutValid, 1'b0);
    check("rst_flag", FlagReg, 5'h00);
    check("rst_halt", Halted, 1'b0);
    check("rst_ill",  IllegalOp, 1'b0);
    check("rst_e",    alu_if.E, 1'b0);
    check("rst_mode", alu_if.Mode, 4'h0);
    check("rst_op1",  alu_if.Operand1, 8'h00);
    check("rst_op2",  alu_if.Operand2, 8'h00);

    // LDA 12, LDB 5, ALU add, OUT, HALT
    do_reset();
    imem[0] = 12'h10C; imem[1] = 12'h205; imem[2] = 12'h300;
    imem[3] = 12'h600; imem[4] = 12'hF00;
    start_prog();
    e_cnt = 0; v_cnt = 0; v_data = '0;
    for (int n = 1; n <= 20; n++) begin
      tick(1);
      if (alu_if.E) e_cnt++;
      if (OutValid) begin v_cnt++; v_data = DataOut; end
      if (n == 8)  check("p1_e_exec", alu_if.E, 1'b1);
      if (n == 12) check("p1_ovld_c12", OutValid, 1'b1);
      if (n == 14) check("p1_halt_c14", Halted, 1'b0);
      if (n == 15) check("p1_halt_c15", Halted, 1'b1);
    end
    check("p1_e_cnt",  e_cnt, 1);
    check("p1_v_cnt",  v_cnt, 1);
    check("p1_v_data", v_data, 8'd17);
    check("p1_dout",   DataOut, 8'd17);
    check("p1_acc",    alu_if.Operand1, 8'd17);
    check("p1_dr",     alu_if.Operand2, 8'd5);
    start_prog();
    tick(3);
    check("p1_halt_sink", Halted, 1'b1);

    // LDA 5, LDB 5, ALU sub, JZ 0x10 ; 0x10: LDA 3, JZ 0x20 ; 0x12: HALT
    do_reset();
    imem[0] = 12'h105; imem[1] = 12'h205; imem[2] = 12'h301; imem[3] = 12'h510;
    imem[8'h10] = 12'h103; imem[8'h11] = 12'h520; imem[8'h12] = 12'hF00;
    start_prog();
    tick(12);
    check("p2_acc_zero", alu_if.Operand1, 8'h00);
    check("p2_flagreg",  FlagReg, 5'b10000);
    check("p2_jz_taken", PcAddr, 8'h10);
    check("p2_mode_hold", alu_if.Mode, 4'h1);
    tick(6);
    check("p2_jz_not",   PcAddr, 8'h12);
    check("p2_acc3",     alu_if.Operand1, 8'h03);

    // JMP 0xFF ; 0xFF: NOP -> wraps to 0 ; Start mid-run ignored
    do_reset();
    imem[0] = 12'h4FF; imem[8'hFF] = 12'h000;
    start_prog();
    tick(3);
    check("p3_jmp_ff", PcAddr, 8'hFF);
    tick(1);
    Start = 1'b1;
    tick(1);
    Start = 1'b0;
    tick(1);
    check("p3_wrap", PcAddr, 8'h00);
    tick(3);
    check("p3_spin", PcAddr, 8'hFF);
    check("p3_halt", Halted, 1'b0);

    // LDA 7, illegal 0x9AB, OUT, HALT
    do_reset();
    imem[0] = 12'h107; imem[1] = 12'h9AB; imem[2] = 12'h600; imem[3] = 12'hF00;
    start_prog();
    tick(5);
    check("p4_ill_pre", IllegalOp, 1'b0);
    tick(1);
    check("p4_ill_set", IllegalOp, 1'b1);
    check("p4_acc",     alu_if.Operand1, 8'h07);
    tick(3);
    check("p4_ovld",    OutValid, 1'b1);
    check("p4_dout",    DataOut, 8'h07);
    tick(3);
    check("p4_ill_stick", IllegalOp, 1'b1);
    check("p4_halt",    Halted, 1'b1);

    // Reset during EXEC of the ALU instruction
    do_reset();
    imem[0] = 12'h10C; imem[1] = 12'h205; imem[2] = 12'h300;
    imem[3] = 12'h600; imem[4] = 12'hF00;
    start_prog();
    tick(8);
    check("p5_e_before", alu_if.E, 1'b1);
    rst_n = 1'b0;
    #1;
    check("p5_e_rst",   alu_if.E, 1'b0);
    check("p5_acc_rst", alu_if.Operand1, 8'h00);
    check("p5_dr_rst",  alu_if.Operand2, 8'h00);
    check("p5_pc_rst",  PcAddr, 8'h00);
    check("p5_flag_rst", FlagReg, 5'h00);
    @(negedge clk);
    rst_n = 1'b1;
    tick(3);
    check("p5_idle_pc",  PcAddr, 8'h00);
    check("p5_idle_acc", alu_if.Operand1, 8'h00);
    check("p5_idle_halt", Halted, 1'b0);
    start_prog();
    tick(15);
    check("p5_rerun_halt", Halted, 1'b1);
    check("p5_rerun_dout", DataOut, 8'd17);

`ifdef MCU_SINGLE_STEP_EN
    // Single-step: FETCH waits for Step
    do_reset();
    imem[0] = 12'h101; imem[1] = 12'h102; imem[2] = 12'hF00;
    Step = 1'b0;
    start_prog();
    tick(10);
    check("ss_frozen_pc",  PcAddr, 8'h00);
    check("ss_frozen_acc", alu_if.Operand1, 8'h00);
    Step = 1'b1;
    tick(1);
    Step = 1'b0;
    tick(6);
    check("ss_one_pc",  PcAddr, 8'h01);
    check("ss_one_acc", alu_if.Operand1, 8'h01);
    Step = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
